// File: rtl/decode_hazard_stage.sv
// Decode stage: bypassed register bank, main decoder, load-use/JR hazard detection,
// in-stage jump resolution and the registered ID/EX pipeline register with HALT latch.
module decode_hazard_stage #(
  parameter int NB_INST   = 32,
  parameter int NB_PC     = 32,
  parameter int NB_DATA   = 32,
  parameter int NB_REG    = 5,
  parameter int N_REGS    = 32,
  parameter int NB_OPCODE = 6
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_valid,
  input  logic [NB_INST-1:0]   i_inst,
  input  logic [NB_PC-1:0]     i_pc,
  input  logic                 i_flush,
  input  logic                 i_wb_write,
  input  logic [NB_REG-1:0]    i_wb_addr,
  input  logic [NB_DATA-1:0]   i_wb_data,
  input  logic [NB_REG-1:0]    i_dbg_addr,
  output logic [NB_DATA-1:0]   o_dbg_data,
  output logic                 o_stall,
  output logic                 o_redirect,
  output logic [NB_PC-1:0]     o_redirect_pc,
  output logic                 o_halted,
  output logic                 o_valid,
  output logic                 o_reg_write,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic                 o_mem_to_reg,
  output logic                 o_alu_src,
  output logic                 o_reg_dest,
  output logic                 o_branch,
  output logic [NB_OPCODE-1:0] o_alu_op,
  output logic [NB_DATA-1:0]   o_data_a,
  output logic [NB_DATA-1:0]   o_data_b,
  output logic [NB_DATA-1:0]   o_imm,
  output logic [NB_DATA-1:0]   o_shamt,
  output logic [NB_REG-1:0]    o_rs,
  output logic [NB_REG-1:0]    o_rt,
  output logic [NB_REG-1:0]    o_rd,
  output logic [NB_PC-1:0]     o_pc
);

  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  localparam logic [NB_REG:0] REG_LIMIT = (NB_REG+1)'(N_REGS);

  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_to_reg;
    logic                 alu_src;
    logic                 reg_dest;
    logic                 branch;
    logic [NB_OPCODE-1:0] alu_op;
    logic [NB_DATA-1:0]   data_a;
    logic [NB_DATA-1:0]   data_b;
    logic [NB_DATA-1:0]   imm;
    logic [NB_DATA-1:0]   shamt;
    logic [NB_REG-1:0]    rs;
    logic [NB_REG-1:0]    rt;
    logic [NB_REG-1:0]    rd;
    logic [NB_PC-1:0]     pc;
  } idex_t;

  function automatic logic in_range(input logic [NB_REG-1:0] addr);
    return {1'b0, addr} < REG_LIMIT;
  endfunction

  state_t              state;
  idex_t               idex;
  idex_t               dec;
  idex_t               idex_next;
  logic [NB_DATA-1:0]  regs [N_REGS];

  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic [NB_REG-1:0]   rs;
  logic [NB_REG-1:0]   rt;
  logic [NB_REG-1:0]   rd;
  logic [NB_DATA-1:0]  rs_val;
  logic [NB_DATA-1:0]  rt_val;
  logic [NB_DATA-1:0]  imm_ext;
  logic [NB_DATA-1:0]  shamt_ext;
  logic [NB_PC-1:0]    jump_target;

  logic known;
  logic uses_rt;
  logic jump;
  logic jump_reg;
  logic is_halt;
  logic link;
  logic [NB_REG-1:0] idex_dest;
  logic load_use;
  logic jr_hazard;
  logic load;

  assign opcode    = i_inst[31:26];
  assign funct     = i_inst[5:0];
  assign rs        = NB_REG'(i_inst[25:21]);
  assign rt        = NB_REG'(i_inst[20:16]);
  assign rd        = NB_REG'(i_inst[15:11]);
  assign imm_ext   = {{(NB_DATA-16){i_inst[15]}}, i_inst[15:0]};
  assign shamt_ext = {{(NB_DATA-5){1'b0}}, i_inst[10:6]};
  assign jump_target = {i_pc[NB_PC-1:28], i_inst[25:0], 2'b00};

  // WB data written this cycle is forwarded so the operand never sees a stale value.
  assign rs_val = (rs == '0) ? '0 :
                  (i_wb_write && i_wb_addr == rs) ? i_wb_data :
                  in_range(rs) ? regs[rs] : '0;
  assign rt_val = (rt == '0) ? '0 :
                  (i_wb_write && i_wb_addr == rt) ? i_wb_data :
                  in_range(rt) ? regs[rt] : '0;

  assign o_dbg_data = (i_dbg_addr != '0 && in_range(i_dbg_addr)) ? regs[i_dbg_addr] : '0;

  always_comb begin
    dec        = '0;
    known      = 1'b0;
    uses_rt    = 1'b0;
    jump       = 1'b0;
    jump_reg   = 1'b0;
    is_halt    = 1'b0;
    link       = 1'b0;
    dec.valid  = 1'b1;
    dec.alu_op = NB_OPCODE'(opcode);
    dec.data_a = rs_val;
    dec.data_b = rt_val;
    dec.imm    = imm_ext;
    dec.shamt  = shamt_ext;
    dec.rs     = rs;
    dec.rt     = rt;
    dec.rd     = rd;
    dec.pc     = i_pc;
    case (opcode)
      OP_RTYPE: begin
        known      = 1'b1;
        dec.alu_op = NB_OPCODE'(funct);
        if (funct == FN_JR) begin
          jump_reg = 1'b1;
        end else if (funct == FN_JALR) begin
          jump_reg      = 1'b1;
          link          = 1'b1;
          dec.reg_write = 1'b1;
          dec.reg_dest  = 1'b1;
        end else begin
          uses_rt       = 1'b1;
          dec.reg_write = 1'b1;
          dec.reg_dest  = 1'b1;
        end
      end
      OP_LW: begin
        known          = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
      end
      OP_SW: begin
        known         = 1'b1;
        uses_rt       = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        known      = 1'b1;
        uses_rt    = 1'b1;
        dec.branch = 1'b1;
      end
      OP_ADDI: begin
        known         = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_J: begin
        known = 1'b1;
        jump  = 1'b1;
      end
      OP_JAL: begin
        known         = 1'b1;
        jump          = 1'b1;
        link          = 1'b1;
        dec.reg_write = 1'b1;
        dec.reg_dest  = 1'b1;
        dec.rd        = NB_REG'(31);
      end
      OP_HALT: begin
        known   = 1'b1;
        is_halt = 1'b1;
      end
      default: known = 1'b0;
    endcase
    // Link instructions carry the return address through the ALU as data_a + 0.
    if (link) begin
      dec.data_a = NB_DATA'(i_pc);
      dec.imm    = '0;
    end
  end

  assign idex_dest = o_reg_dest ? o_rd : o_rt;
  assign load_use  = o_valid && o_mem_read && (o_rt != '0) &&
                     ((o_rt == rs) || (uses_rt && (o_rt == rt)));
  assign jr_hazard = jump_reg && o_valid && o_reg_write && (idex_dest == rs);

  assign o_stall       = (state == ST_HALTED) || (i_valid && (load_use || jr_hazard));
  assign o_redirect    = i_valid && !o_stall && !i_flush && (jump || jump_reg);
  assign o_redirect_pc = jump ? jump_target : NB_PC'(rs_val);

  assign load      = i_valid && !i_flush && !o_stall && known;
  assign idex_next = load ? dec : '0;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= ST_RUN;
      idex  <= '0;
    end else if (i_enable) begin
      idex <= idex_next;
      if (load && is_halt) state <= ST_HALTED;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      regs <= '{default: '0};
    end else if (i_enable && i_wb_write && i_wb_addr != '0 && in_range(i_wb_addr)) begin
      regs[i_wb_addr] <= i_wb_data;
    end
  end

  assign o_halted     = (state == ST_HALTED);
  assign o_valid      = idex.valid;
  assign o_reg_write  = idex.reg_write;
  assign o_mem_read   = idex.mem_read;
  assign o_mem_write  = idex.mem_write;
  assign o_mem_to_reg = idex.mem_to_reg;
  assign o_alu_src    = idex.alu_src;
  assign o_reg_dest   = idex.reg_dest;
  assign o_branch     = idex.branch;
  assign o_alu_op     = idex.alu_op;
  assign o_data_a     = idex.data_a;
  assign o_data_b     = idex.data_b;
  assign o_imm        = idex.imm;
  assign o_shamt      = idex.shamt;
  assign o_rs         = idex.rs;
  assign o_rt         = idex.rt;
  assign o_rd         = idex.rd;
  assign o_pc         = idex.pc;

endmodule

// File: tb/tb_decode_hazard_stage.sv
// Scoreboarded directed bench for decode_hazard_stage: bypass, stalls, jumps, HALT, enable hold.
module tb_decode_hazard_stage;

  logic        clk = 1'b0;
  logic        i_reset, i_enable, i_valid, i_flush, i_wb_write;
  logic [31:0] i_inst, i_pc, i_wb_data;
  logic [4:0]  i_wb_addr, i_dbg_addr;
  logic [31:0] o_dbg_data, o_redirect_pc, o_data_a, o_data_b, o_imm, o_shamt, o_pc;
  logic        o_stall, o_redirect, o_halted, o_valid, o_reg_write, o_mem_read, o_mem_write;
  logic        o_mem_to_reg, o_alu_src, o_reg_dest, o_branch;
  logic [5:0]  o_alu_op;
  logic [4:0]  o_rs, o_rt, o_rd;

  always #5 clk = ~clk;

  decode_hazard_stage #(
    .NB_INST(32), .NB_PC(32), .NB_DATA(32), .NB_REG(5), .N_REGS(32), .NB_OPCODE(6)
  ) dut (
    .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_inst(i_inst), .i_pc(i_pc), .i_flush(i_flush), .i_wb_write(i_wb_write),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_dbg_addr(i_dbg_addr),
    .o_dbg_data(o_dbg_data), .o_stall(o_stall), .o_redirect(o_redirect),
    .o_redirect_pc(o_redirect_pc), .o_halted(o_halted), .o_valid(o_valid),
    .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_to_reg(o_mem_to_reg), .o_alu_src(o_alu_src), .o_reg_dest(o_reg_dest),
    .o_branch(o_branch), .o_alu_op(o_alu_op), .o_data_a(o_data_a), .o_data_b(o_data_b),
    .o_imm(o_imm), .o_shamt(o_shamt), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_pc(o_pc)
  );

  typedef struct {
    logic [5:0]  alu_op;
    logic [6:0]  ctrl;
    logic [31:0] a, b, imm, shamt;
    logic [4:0]  rs, rt, rd;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic        en_q     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dest, branch}
  task automatic push(input logic [5:0] op, input logic [6:0] ctrl, input logic [31:0] a, b,
                      imm, shamt, input logic [4:0] rs, rt, rd, input logic [31:0] pc);
    exp_t e;
    e.alu_op = op; e.ctrl = ctrl; e.a = a; e.b = b; e.imm = imm; e.shamt = shamt;
    e.rs = rs; e.rt = rt; e.rd = rd; e.pc = pc;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic issue(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    i_valid = v; i_inst = inst; i_pc = pc;
  endtask

  task automatic wb(input logic w, input logic [4:0] addr, input logic [31:0] data);
    i_wb_write = w; i_wb_addr = addr; i_wb_data = data;
  endtask

  always @(posedge clk) en_q <= i_enable;

  // Monitor: every freshly loaded valid ID/EX entry must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (en_q && o_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL idex_unexpected: got valid entry alu_op=0x%0h pc=0x%0h, expected none",
                   o_alu_op, o_pc);
        end else begin
          e = sb.pop_front();
          chk("idex_alu_op", {26'd0, o_alu_op}, {26'd0, e.alu_op});
          chk("idex_ctrl", {25'd0, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg,
                            o_alu_src, o_reg_dest, o_branch}, {25'd0, e.ctrl});
          chk("idex_data_a", o_data_a, e.a);
          chk("idex_data_b", o_data_b, e.b);
          chk("idex_imm", o_imm, e.imm);
          chk("idex_shamt", o_shamt, e.shamt);
          chk("idex_rs", {27'd0, o_rs}, {27'd0, e.rs});
          chk("idex_rt", {27'd0, o_rt}, {27'd0, e.rt});
          chk("idex_rd", {27'd0, o_rd}, {27'd0, e.rd});
          chk("idex_pc", o_pc, e.pc);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got no end of stimulus, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_enable = 1'b1; i_flush = 1'b0; i_dbg_addr = '0;
    issue(1'b0, 32'h0, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_halted", {31'd0, o_halted}, 32'd0);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    chk("rst_redirect", {31'd0, o_redirect}, 32'd0);
    chk("rst_alu_op", {26'd0, o_alu_op}, 32'd0);
    i_reset = 1'b0;

    // ADD r6,r5,r0 with WB r5=0x1234 in the same cycle
    issue(1'b1, enc_r(5'd5, 5'd0, 5'd6, 6'h20), 32'h100);
    wb(1'b1, 5'd5, 32'h1234);
    #1 chk("bypass_stall", {31'd0, o_stall}, 32'd0);
    push(6'h20, 7'b1000010, 32'h1234, 32'h0, 32'h3020, 32'h0, 5'd5, 5'd0, 5'd6, 32'h100);
    @(negedge clk);

    // LW r2,0(r1)
    issue(1'b1, enc_i(6'h23, 5'd1, 5'd2, 16'h0000), 32'h104);
    wb(1'b0, 5'd0, 32'h0);
    #1 chk("lw_stall", {31'd0, o_stall}, 32'd0);
    push(6'h23, 7'b1101100, 32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd0, 32'h104);
    @(negedge clk);

    // ADD r3,r2,r4 behind the load: one stall cycle
    issue(1'b1, enc_r(5'd2, 5'd4, 5'd3, 6'h20), 32'h108);
    i_dbg_addr = 5'd5;
    #1 chk("lu_stall", {31'd0, o_stall}, 32'd1);
    chk("dbg_r5", o_dbg_data, 32'h1234);
    @(negedge clk);
    chk("lu_bubble", {31'd0, o_valid}, 32'd0);
    wb(1'b1, 5'd4, 32'h55);
    #1 chk("lu_release", {31'd0, o_stall}, 32'd0);
    push(6'h20, 7'b1000010, 32'h0, 32'h55, 32'h1820, 32'h0, 5'd2, 5'd4, 5'd3, 32'h108);
    @(negedge clk);

    // J 0x40 at PC+4 = 0x10000008, then flushed in the same cycle
    issue(1'b1, {6'h02, 26'h40}, 32'h10000008);
    wb(1'b0, 5'd0, 32'h0);
    #1 chk("j_redirect", {31'd0, o_redirect}, 32'd1);
    chk("j_target", o_redirect_pc, 32'h10000100);
    chk("j_stall", {31'd0, o_stall}, 32'd0);
    i_flush = 1'b1;
    #1 chk("j_flush_redirect", {31'd0, o_redirect}, 32'd0);
    @(negedge clk);
    i_flush = 1'b0;
    chk("flush_bubble", {31'd0, o_valid}, 32'd0);

    // ADDI r31,r0,8 followed by JR r31
    issue(1'b1, enc_i(6'h08, 5'd0, 5'd31, 16'h0008), 32'h200);
    push(6'h08, 7'b1000100, 32'h0, 32'h0, 32'h8, 32'h0, 5'd0, 5'd31, 5'd0, 32'h200);
    @(negedge clk);
    issue(1'b1, enc_r(5'd31, 5'd0, 5'd0, 6'h08), 32'h204);
    #1 chk("jr_stall", {31'd0, o_stall}, 32'd1);
    chk("jr_stall_redirect", {31'd0, o_redirect}, 32'd0);
    @(negedge clk);
    wb(1'b1, 5'd31, 32'h8);
    #1 chk("jr_release", {31'd0, o_stall}, 32'd0);
    chk("jr_redirect", {31'd0, o_redirect}, 32'd1);
    chk("jr_target", o_redirect_pc, 32'h8);
    push(6'h08, 7'b0000000, 32'h8, 32'h0, 32'h8, 32'h0, 5'd31, 5'd0, 5'd0, 32'h204);
    @(negedge clk);

    // HALT
    issue(1'b1, 32'hFC000000, 32'h300);
    wb(1'b0, 5'd0, 32'h0);
    #1 chk("pre_halt_halted", {31'd0, o_halted}, 32'd0);
    chk("pre_halt_stall", {31'd0, o_stall}, 32'd0);
    push(6'h3F, 7'b0000000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h300);
    @(negedge clk);
    chk("halted_set", {31'd0, o_halted}, 32'd1);
    issue(1'b1, enc_r(5'd2, 5'd4, 5'd3, 6'h20), 32'h304);
    wb(1'b1, 5'd7, 32'h9);
    i_dbg_addr = 5'd7;
    #1 chk("halt_stall", {31'd0, o_stall}, 32'd1);
    @(negedge clk);
    chk("halt_bubble", {31'd0, o_valid}, 32'd0);
    chk("halt_drain_r7", o_dbg_data, 32'h9);
    chk("halted_sticky", {31'd0, o_halted}, 32'd1);
    issue(1'b0, 32'h0, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    #1 chk("halt_stall_idle", {31'd0, o_stall}, 32'd1);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    #1 chk("rst_clear_halted", {31'd0, o_halted}, 32'd0);
    chk("rst_clear_stall", {31'd0, o_stall}, 32'd0);
    chk("rst_clear_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_clear_r7", o_dbg_data, 32'h0);
    @(negedge clk);

    // ADDI r9,r0,-1 while WB targets r0
    issue(1'b1, enc_i(6'h08, 5'd0, 5'd9, 16'hFFFF), 32'h400);
    wb(1'b1, 5'd0, 32'hFFFF);
    i_dbg_addr = 5'd0;
    #1 chk("dbg_r0_pre", o_dbg_data, 32'h0);
    push(6'h08, 7'b1000100, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h1F, 5'd0, 5'd9, 5'd31, 32'h400);
    @(negedge clk);

    // Three frozen cycles with JR r9 in ID and a WB write pending
    i_enable = 1'b0;
    issue(1'b1, enc_r(5'd9, 5'd0, 5'd0, 6'h08), 32'h500);
    wb(1'b1, 5'd8, 32'h77);
    #1 chk("dbg_r0", o_dbg_data, 32'h0);
    i_dbg_addr = 5'd8;
    for (int k = 0; k < 3; k++) begin
      #1 chk("hold_stall", {31'd0, o_stall}, 32'd1);
      chk("hold_valid", {31'd0, o_valid}, 32'd1);
      chk("hold_imm", o_imm, 32'hFFFFFFFF);
      chk("hold_pc", o_pc, 32'h400);
      chk("hold_r8", o_dbg_data, 32'h0);
      @(negedge clk);
    end

    // Unknown opcode decodes to a bubble
    i_enable = 1'b1;
    issue(1'b1, 32'hF8000000, 32'h504);
    wb(1'b0, 5'd0, 32'h0);
    #1 chk("unk_stall", {31'd0, o_stall}, 32'd0);
    @(negedge clk);
    chk("unk_bubble", {31'd0, o_valid}, 32'd0);
    chk("no_write_r8", o_dbg_data, 32'h0);
    issue(1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("sb_drain", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
